sram_ctrl: RTL and testbench

Request/response front end for the single-port word SRAM model. Accepts one load/store request at a time on a valid/ready channel, drives the `sram_if` master side, and returns one response per request. Byte-strobed (partial) stores are implemented as read-modify-write, because the SRAM has no byte enables. Sits between the core/bus fabric and `sram`.

---
 rtl/sram_ctrl_if.sv | 17 +
 rtl/sram_ctrl.sv | 117 +++++++++++
 tb/tb_sram_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// sram_if: master/slave bundle between sram_ctrl and the single-port word SRAM.
//   addr  [AW-1:0]  word address (master -> slave)
//   wen             1 = write on posedge, 0 = read addr into rdata on posedge
//   wdata [DW-1:0]  write data (master -> slave)
//   rdata [DW-1:0]  registered read data (slave -> master)
interface sram_if #(
   parameter int AW = 15,
   parameter int DW = 32
);
   logic [AW-1:0] addr;
   logic          wen;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport master (output addr, output wen, output wdata, input rdata);
   modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready load/store front end for a single-port word SRAM.
// One request outstanding at a time; byte-strobed stores become
// read-modify-write since the SRAM has no byte enables.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_vld/req_rdy        request handshake
//   req_addr, req_wen      word address, 1 = store / 0 = load
//   req_wdata, req_wstrb   store data and per-byte strobes
//   rsp_vld/rsp_rdy        response handshake
//   rsp_rdata              load data (0 for stores)
//   sram_rw                SRAM master port
module sram_ctrl #(
   parameter int AW = 15,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_vld,
   output logic            req_rdy,
   input  logic [AW-1:0]   req_addr,
   input  logic            req_wen,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_wstrb,
   output logic            rsp_vld,
   input  logic            rsp_rdy,
   output logic [DW-1:0]   rsp_rdata,
   sram_if.master          sram_rw
);
   localparam int SW = DW / 8;

   typedef enum logic [1:0] {IDLE, RD, MRG, RSP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic [DW-1:0]   rdata_q, rdata_d;

   logic            accept;
   logic            full_strb;
   logic [DW-1:0]   merged;

   always_comb begin
      req_rdy   = (state_q == IDLE) && !rst;
      rsp_vld   = (state_q == RSP);
      rsp_rdata = rdata_q;
      accept    = req_vld && req_rdy;
      full_strb = &req_wstrb;

      // Old word arrives on rdata the cycle after the accept-edge read.
      merged = '0;
      for (int unsigned i = 0; i < SW; i++) begin
         merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : sram_rw.rdata[8*i +: 8];
      end

      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;

      sram_rw.addr  = addr_q;
      sram_rw.wen   = 1'b0;
      sram_rw.wdata = wdata_q;

      unique case (state_q)
         IDLE: begin
            sram_rw.addr  = req_addr;
            sram_rw.wdata = req_wdata;
            sram_rw.wen   = accept && req_wen && full_strb;
            if (accept) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               if (!req_wen) begin
                  state_d = RD;
               end else if (full_strb || (req_wstrb == '0)) begin
                  rdata_d = '0;
                  state_d = RSP;
               end else begin
                  state_d = MRG;
               end
            end
         end
         RD: begin
            rdata_d = sram_rw.rdata;
            state_d = RSP;
         end
         MRG: begin
            sram_rw.wen   = !rst;
            sram_rw.wdata = merged;
            rdata_d       = '0;
            state_d       = RSP;
         end
         RSP: begin
            if (rsp_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_vld;
   logic        req_rdy;
   logic [14:0] req_addr;
   logic        req_wen;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int wr_cnt = 0;
   int wr_cyc = -1;
   int rst_wen = 0;

   logic [31:0] sb[$];
   logic [31:0] mem [0:32767];

   sram_if #(.AW(15), .DW(32)) bus ();

   sram_ctrl #(.AW(15), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_vld   (req_vld),
      .req_rdy   (req_rdy),
      .req_addr  (req_addr),
      .req_wen   (req_wen),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_vld   (rsp_vld),
      .rsp_rdy   (rsp_rdy),
      .rsp_rdata (rsp_rdata),
      .sram_rw   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: write on wen, otherwise registered read.
   always @(posedge clk) begin
      if (bus.wen) mem[bus.addr] <= bus.wdata;
      else         bus.rdata <= mem[bus.addr];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.wen) begin
         wr_cnt <= wr_cnt + 1;
         wr_cyc <= cyc;
         if (rst) rst_wen <= rst_wen + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request/response; exp_data is the scoreboard entry for the response.
   task automatic do_op(input string tag, input logic [14:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_data, input int exp_lat,
                        input int exp_wr, input int wr_off, input int hold);
      int n;
      int acc_cyc;
      int w0;
      logic [31:0] first;
      logic [31:0] exp;
      @(negedge clk);
      req_vld = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wstrb = s;
      rsp_rdy = 1'b0;
      sb.push_back(exp_data);
      n = 0;
      while (!req_rdy && n < 10) begin @(negedge clk); n++; end
      chk({tag, "_rdy"}, {31'd0, req_rdy}, 32'd1);
      acc_cyc = cyc;
      w0 = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_vld = 1'b0;
      n = 0;
      while (!rsp_vld && n < 10) begin @(posedge clk); @(negedge clk); n++; end
      chk({tag, "_lat"}, n, exp_lat);
      first = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_hold_vld"}, {31'd0, rsp_vld}, 32'd1);
         chk({tag, "_hold_data"}, rsp_rdata, first);
         chk({tag, "_hold_rdy"}, {31'd0, req_rdy}, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      exp = sb.pop_front();
      chk({tag, "_data"}, rsp_rdata, exp);
      chk({tag, "_wrcnt"}, wr_cnt - w0, exp_wr);
      if (exp_wr != 0) chk({tag, "_wrcyc"}, wr_cyc, acc_cyc + wr_off);
      rsp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_rdy = 1'b0;
      chk({tag, "_done_vld"}, {31'd0, rsp_vld}, 32'd0);
      chk({tag, "_done_rdy"}, {31'd0, req_rdy}, 32'd1);
   endtask

   initial begin
      int w0;
      rst = 1'b1; req_vld = 1'b1; req_addr = 15'h10; req_wen = 1'b1;
      req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF; rsp_rdy = 1'b0;

      // Reset with a pending request: nothing may be accepted or written.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
         chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
         chk("rst_rsp_rdata", rsp_rdata, 32'd0);
         chk("rst_wen", {31'd0, bus.wen}, 32'd0);
      end
      rst = 1'b0; req_vld = 1'b0;
      #1;
      chk("rst_release_rdy", {31'd0, req_rdy}, 32'd1);
      chk("rst_no_write", wr_cnt, 0);

      // Full store then load.
      do_op("st_full", 15'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'd0, 0, 1, 0, 0);
      do_op("ld_full", 15'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1, 0, 0, 0);

      // Partial store RMW: only byte 1 replaced, write on the MRG edge.
      do_op("pre_20", 15'h20, 1'b1, 32'h11223344, 4'hF, 32'd0, 0, 1, 0, 0);
      do_op("st_part", 15'h20, 1'b1, 32'hAABBCCDD, 4'b0010, 32'd0, 1, 1, 1, 0);
      do_op("ld_part", 15'h20, 1'b0, 32'h0, 4'h0, 32'h1122CC44, 1, 0, 0, 0);

      // Upper/lower bytes mixed strobe.
      do_op("st_part2", 15'h20, 1'b1, 32'h99887766, 4'b1001, 32'd0, 1, 1, 1, 0);
      do_op("ld_part2", 15'h20, 1'b0, 32'h0, 4'h0, 32'h9922CC66, 1, 0, 0, 0);

      // Backpressure on a load.
      do_op("ld_bp", 15'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1, 0, 0, 5);

      // Zero-strobe store leaves memory alone.
      do_op("pre_30", 15'h30, 1'b1, 32'h55AA55AA, 4'hF, 32'd0, 0, 1, 0, 0);
      do_op("st_zero", 15'h30, 1'b1, 32'h12345678, 4'h0, 32'd0, 0, 0, 0, 0);
      do_op("ld_zero", 15'h30, 1'b0, 32'h0, 4'h0, 32'h55AA55AA, 1, 0, 0, 0);

      // Reset during MRG abandons the write.
      do_op("pre_40", 15'h40, 1'b1, 32'h01020304, 4'hF, 32'd0, 0, 1, 0, 0);
      @(negedge clk);
      req_vld = 1'b1; req_addr = 15'h40; req_wen = 1'b1;
      req_wdata = 32'hFFFFFFFF; req_wstrb = 4'b0001;
      chk("mrg_rdy", {31'd0, req_rdy}, 32'd1);
      w0 = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_vld = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrg_rst_wen", {31'd0, bus.wen}, 32'd0);
      repeat (2) @(negedge clk);
      chk("mrg_rst_vld", {31'd0, rsp_vld}, 32'd0);
      chk("mrg_rst_wr", wr_cnt - w0, 0);
      rst = 1'b0;
      do_op("ld_mrg_rst", 15'h40, 1'b0, 32'h0, 4'h0, 32'h01020304, 1, 0, 0, 0);

      // Back-to-back write then read to a fresh address.
      do_op("st_wr", 15'h7FFF, 1'b1, 32'hCAFEF00D, 4'hF, 32'd0, 0, 1, 0, 0);
      do_op("ld_wr", 15'h7FFF, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1, 0, 0, 0);

      chk("rst_wen_total", rst_wen, 0);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
